// File: rtl/link_pair_scheduler.sv
// link_pair_scheduler: shares the single redirect op-amp resource between the
// 1236 and 5478 pair lanes. A granted lane runs POWER -> MAKE -> REDIRECT -> GUARD,
// with round-robin arbitration in IDLE and LinkFault aborting straight into GUARD.
module link_pair_scheduler #(
  parameter int PowerUpCycles = 8,
  parameter int BurstCycles   = 16,
  parameter int GuardCycles   = 4,
  parameter int CountWidth    = 8
) (
  input  logic Clock100MhzP,
  input  logic Reset,
  input  logic Request1236,
  input  logic Request5478,
  input  logic LinkFault,
  output logic Grant1236,
  output logic Grant5478,
  output logic VoltEnable1236,
  output logic VoltEnable5478,
  output logic Make12To36Enable,
  output logic Redirect12To36Enable,
  output logic Make54To78Enable,
  output logic Redirect54To78Enable,
  output logic Done1236,
  output logic Done5478,
  output logic FaultAbort,
  output logic Busy
);

  typedef enum logic [2:0] {
    st_idle,
    st_power,
    st_make,
    st_redirect,
    st_guard
  } state_t;

  localparam logic [CountWidth-1:0] power_last = CountWidth'(PowerUpCycles - 1);
  localparam logic [CountWidth-1:0] burst_last = CountWidth'(BurstCycles - 1);
  localparam logic [CountWidth-1:0] guard_last = CountWidth'(GuardCycles - 1);

  // owner/last encoding: 0 = lane 1236, 1 = lane 5478
  state_t                state_q, state_n;
  logic [CountWidth-1:0] cnt_q, cnt_n;
  logic                  owner_q, owner_n;
  logic                  last_q, last_n;
  logic                  done_n, abort_n;
  logic                  active_n;

  // State, phase counter, owner and round-robin history
  always_ff @(posedge Clock100MhzP or posedge Reset) begin
    if (Reset) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      owner_q <= owner_n;
      last_q  <= last_n;
    end
  end

  // Next-state: arbitration in IDLE, fixed-length phases, fault abort into GUARD
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 1'b1;
    owner_n = owner_q;
    last_n  = last_q;
    done_n  = 1'b0;
    abort_n = 1'b0;
    unique case (state_q)
      st_idle: begin
        cnt_n = '0;
        if (Request1236 || Request5478) begin
          owner_n = (Request1236 && Request5478) ? ~last_q : Request5478;
          last_n  = owner_n;
          state_n = st_power;
        end
      end
      st_power: begin
        if (LinkFault) begin
          state_n = st_guard;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (cnt_q == power_last) begin
          state_n = st_make;
          cnt_n   = '0;
        end
      end
      st_make: begin
        if (LinkFault) begin
          state_n = st_guard;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (cnt_q == burst_last) begin
          state_n = st_redirect;
          cnt_n   = '0;
        end
      end
      st_redirect: begin
        if (LinkFault) begin
          state_n = st_guard;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (cnt_q == burst_last) begin
          state_n = st_guard;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      st_guard: begin
        if (cnt_q == guard_last) begin
          state_n = st_idle;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = st_idle;
        cnt_n   = '0;
      end
    endcase
    active_n = (state_n == st_power) || (state_n == st_make) || (state_n == st_redirect);
  end

  // Registered outputs decoded from the next state so they move with the state
  always_ff @(posedge Clock100MhzP or posedge Reset) begin
    if (Reset) begin
      Grant1236            <= 1'b0;
      Grant5478            <= 1'b0;
      VoltEnable1236       <= 1'b0;
      VoltEnable5478       <= 1'b0;
      Make12To36Enable     <= 1'b0;
      Redirect12To36Enable <= 1'b0;
      Make54To78Enable     <= 1'b0;
      Redirect54To78Enable <= 1'b0;
      Done1236             <= 1'b0;
      Done5478             <= 1'b0;
      FaultAbort           <= 1'b0;
      Busy                 <= 1'b0;
    end else begin
      Grant1236            <= active_n && !owner_n;
      Grant5478            <= active_n &&  owner_n;
      VoltEnable1236       <= active_n && !owner_n;
      VoltEnable5478       <= active_n &&  owner_n;
      Make12To36Enable     <= (state_n == st_make)     && !owner_n;
      Redirect12To36Enable <= (state_n == st_redirect) && !owner_n;
      Make54To78Enable     <= (state_n == st_make)     &&  owner_n;
      Redirect54To78Enable <= (state_n == st_redirect) &&  owner_n;
      Done1236             <= done_n && !owner_q;
      Done5478             <= done_n &&  owner_q;
      FaultAbort           <= abort_n;
      Busy                 <= (state_n != st_idle);
    end
  end

endmodule

// File: tb/tb_link_pair_scheduler.sv
// tb_link_pair_scheduler: directed scenarios plus randomized traffic, checked every
// cycle against a timeline model (age since grant -> phase) of the lane scheduler.
module tb_link_pair_scheduler;

  localparam int P = 8;
  localparam int B = 16;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst;
  logic req1236, req5478, fault;
  logic g1236, g5478, v1236, v5478, mk12, rd12, mk54, rd54, d1236, d5478, fab, busy;
  logic [11:0] dut_vec;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // timeline model state
  bit m_busy;
  bit m_owner;
  bit m_last;
  bit m_aborted;
  int m_age;
  int m_gstart;

  link_pair_scheduler #(
    .PowerUpCycles(P),
    .BurstCycles  (B),
    .GuardCycles  (G),
    .CountWidth   (8)
  ) dut (
    .Clock100MhzP        (clk),
    .Reset               (rst),
    .Request1236         (req1236),
    .Request5478         (req5478),
    .LinkFault           (fault),
    .Grant1236           (g1236),
    .Grant5478           (g5478),
    .VoltEnable1236      (v1236),
    .VoltEnable5478      (v5478),
    .Make12To36Enable    (mk12),
    .Redirect12To36Enable(rd12),
    .Make54To78Enable    (mk54),
    .Redirect54To78Enable(rd54),
    .Done1236            (d1236),
    .Done5478            (d5478),
    .FaultAbort          (fab),
    .Busy                (busy)
  );

  always #5 clk = ~clk;

  assign dut_vec = {g1236, g5478, v1236, v5478, mk12, rd12, mk54, rd54, d1236, d5478, fab, busy};

  function automatic void model_reset();
    m_busy    = 1'b0;
    m_owner   = 1'b0;
    m_last    = 1'b1;
    m_aborted = 1'b0;
    m_age     = 0;
    m_gstart  = 0;
  endfunction

  // Advance the timeline by one edge given the inputs sampled at that edge
  function automatic void model_step(input bit r1, input bit r2, input bit f);
    if (!m_busy) begin
      if (r1 || r2) begin
        m_owner   = (r1 && r2) ? !m_last : r2;
        m_last    = m_owner;
        m_busy    = 1'b1;
        m_age     = 0;
        m_gstart  = P + 2 * B;
        m_aborted = 1'b0;
      end
    end else begin
      if (f && m_age < m_gstart) begin
        m_gstart  = m_age + 1;
        m_aborted = 1'b1;
      end
      m_age++;
      if (m_age >= m_gstart + G) m_busy = 1'b0;
    end
  endfunction

  function automatic logic [11:0] model_out();
    bit act, mk, rd, fin;
    act = m_busy && (m_age < m_gstart);
    mk  = act && (m_age >= P) && (m_age < P + B);
    rd  = act && (m_age >= P + B);
    fin = m_busy && (m_age == m_gstart);
    return {act && !m_owner, act && m_owner, act && !m_owner, act && m_owner,
            mk && !m_owner, rd && !m_owner, mk && m_owner, rd && m_owner,
            fin && !m_aborted && !m_owner, fin && !m_aborted && m_owner,
            fin && m_aborted, m_busy};
  endfunction

  task automatic step(input logic r1, input logic r2, input logic f, input string name);
    logic [11:0] exp;
    req1236 = r1;
    req5478 = r2;
    fault   = f;
    @(posedge clk);
    model_step(r1, r2, f);
    cyc++;
    #1;
    exp = model_out();
    compared++;
    if (dut_vec !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d outputs=%b expected=%b", name, cyc, dut_vec, exp);
    end
  endtask

  task automatic do_reset();
    req1236 = 1'b0;
    req5478 = 1'b0;
    fault   = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (dut_vec !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_state outputs=%b expected=%b", dut_vec, 12'h000);
    end
  endtask

  task automatic test_single_1236();
    int first_grant = -1;
    int done_at     = -1;
    int idle_at     = -1;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(i == 0, 1'b0, 1'b0, "single1236");
      if (g1236 && first_grant < 0) first_grant = cyc;
      if (d1236 && done_at < 0) done_at = cyc;
      if (first_grant > 0 && !busy && idle_at < 0) idle_at = cyc;
    end
    compared++;
    if (first_grant != 1 || done_at != 41 || idle_at != 45) begin
      mismatched++;
      $display("FAIL single1236_timing grant=%0d done=%0d idle=%0d expected 1/41/45",
               first_grant, done_at, idle_at);
    end
  endtask

  task automatic test_pulse_5478();
    int done_at = -1;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      step(1'b0, i == 0, 1'b0, "pulse5478");
      if (d5478 && done_at < 0) done_at = cyc;
    end
    compared++;
    if (done_at != 41) begin
      mismatched++;
      $display("FAIL pulse5478_done got=%0d expected=41", done_at);
    end
  endtask

  task automatic test_back_to_back();
    int g5_at  = -1;
    int g1_2nd = -1;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, "back_to_back");
      if (g5478 && g5_at < 0) g5_at = cyc;
      if (g1236 && cyc > 46 && g1_2nd < 0) g1_2nd = cyc;
    end
    compared++;
    if (g5_at != 46 || g1_2nd != 91) begin
      mismatched++;
      $display("FAIL alternation g5478=%0d g1236_again=%0d expected 46/91", g5_at, g1_2nd);
    end
  endtask

  task automatic test_fault_make();
    int abort_at = -1;
    int idle_at  = -1;
    bit any_done = 1'b0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(i == 0, 1'b0, cyc == 12, "fault_make");
      if (fab && abort_at < 0) abort_at = cyc;
      if (d1236 || d5478) any_done = 1'b1;
      if (cyc > 1 && !busy && idle_at < 0) idle_at = cyc;
    end
    compared++;
    if (abort_at != 13 || idle_at != 17 || any_done) begin
      mismatched++;
      $display("FAIL fault_make abort=%0d idle=%0d done_seen=%0d expected 13/17/0",
               abort_at, idle_at, any_done);
    end
  endtask

  task automatic test_fault_held();
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, "fault_held");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, "fault_idle");
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) step(i == 0, 1'b0, 1'b0, "pre_async_reset");
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (dut_vec !== 12'h000) begin
      mismatched++;
      $display("FAIL async_reset outputs=%b expected=%b", dut_vec, 12'h000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
    step(1'b0, 1'b1, 1'b0, "post_reset_grant");
    compared++;
    if (g5478 !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_grant Grant5478=%b expected=1", g5478);
    end
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 1'b0, "post_reset_seq");
  endtask

  task automatic test_random();
    logic r1 = 1'b0;
    logic r2 = 1'b0;
    logic f;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) r1 = ~r1;
      if ($urandom_range(0, 19) == 0) r2 = ~r2;
      f = ($urandom_range(0, 59) == 0);
      step(r1, r2, f, "random");
      compared++;
      if ((g1236 && g5478) || (mk12 && rd12) || (mk54 && rd54) ||
          ((mk12 || rd12 || v1236) && !g1236) || ((mk54 || rd54 || v5478) && !g5478)) begin
        mismatched++;
        $display("FAIL invariant cyc=%0d outputs=%b", cyc, dut_vec);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    req1236 = 1'b0;
    req5478 = 1'b0;
    fault   = 1'b0;
    model_reset();
    test_reset();
    test_single_1236();
    test_pulse_5478();
    test_back_to_back();
    test_fault_make();
    test_fault_held();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
